// File: rtl/banked_register_file_pkg.sv
// Shared types and helpers for the cpu16 banked register file.
// Write-port fields use fixed maximum widths; DataWidth must not exceed 64 and IndexWidth must not exceed 8.
package cpu16_regfile_pkg;

    localparam int MAX_DATA_WIDTH  = 64;
    localparam int MAX_INDEX_WIDTH = 8;
    localparam int ZERO_IDX        = 0;

    typedef enum logic {
        BANK_NORMAL = 1'b0,
        BANK_IRQ    = 1'b1
    } bank_state_e;

    typedef struct packed {
        logic                       we;
        logic [MAX_INDEX_WIDTH-1:0] addr;
        logic [MAX_DATA_WIDTH-1:0]  data;
    } write_port_t;

    function automatic int pc_idx(input int num_regs);
        return num_regs - 1;
    endfunction

endpackage

// File: rtl/banked_register_file_bank.sv
// One register bank: two write ports, a PC that counts or loads a vector,
// and combinational read ports. Index 0 has no storage and reads as zero.
module regfile_bank
    import cpu16_regfile_pkg::*;
#(
    parameter int                  DataWidth    = 16,
    parameter int                  NumRegs      = 8,
    parameter int                  NumReadPorts = 2,
    parameter int                  PcStep       = 1,
    parameter logic [DataWidth-1:0] PcInit      = '0,
    parameter int                  IndexWidth   = $clog2(NumRegs)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               count,
    input  logic                               pc_load,
    input  write_port_t [1:0]                  wport,
    input  logic [NumReadPorts*IndexWidth-1:0] raddr,
    output logic [NumReadPorts*DataWidth-1:0]  rdata,
    output logic [DataWidth-1:0]               pc
);

    localparam int PcIdx = pc_idx(NumRegs);

    logic [DataWidth-1:0] regs [ZERO_IDX+1:NumRegs-1];
    logic                 unused_port_bits;

    // Port fields are sized for the widest configuration; only the low bits matter here.
    assign unused_port_bits = ^wport;

    // Port 1 beats port 0, any write beats the PC vector load, and the load beats the increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = ZERO_IDX + 1; i < NumRegs; i++) begin
                regs[i] <= '0;
            end
            regs[PcIdx] <= PcInit;
        end else begin
            for (int i = ZERO_IDX + 1; i < NumRegs; i++) begin
                if (wport[1].we && wport[1].addr == MAX_INDEX_WIDTH'(i)) begin
                    regs[i] <= wport[1].data[DataWidth-1:0];
                end else if (wport[0].we && wport[0].addr == MAX_INDEX_WIDTH'(i)) begin
                    regs[i] <= wport[0].data[DataWidth-1:0];
                end else if (i == PcIdx && pc_load) begin
                    regs[i] <= PcInit;
                end else if (i == PcIdx && count) begin
                    regs[i] <= regs[i] + DataWidth'(PcStep);
                end
            end
        end
    end

    always_comb begin
        rdata = '0;
        for (int k = 0; k < NumReadPorts; k++) begin
            for (int i = ZERO_IDX + 1; i < NumRegs; i++) begin
                if (raddr[k*IndexWidth +: IndexWidth] == IndexWidth'(i)) begin
                    rdata[k*DataWidth +: DataWidth] = regs[i];
                end
            end
        end
    end

    assign pc = regs[PcIdx];

endmodule

// File: rtl/banked_register_file.sv
// cpu16 register file with a NORMAL and an IRQ shadow bank. The bank FSM selects
// which bank receives writes and PC counting and which bank feeds the read ports.
module banked_register_file
    import cpu16_regfile_pkg::*;
#(
    parameter int                   DataWidth    = 16,
    parameter int                   NumRegs      = 8,
    parameter int                   NumReadPorts = 2,
    parameter int                   PcStep       = 1,
    parameter logic [DataWidth-1:0] IrqVector    = 'h0010,
    parameter int                   IndexWidth   = $clog2(NumRegs)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               countEnable,
    input  logic                               we0,
    input  logic [IndexWidth-1:0]              waddr0,
    input  logic [DataWidth-1:0]               wdata0,
    input  logic                               we1,
    input  logic [IndexWidth-1:0]              waddr1,
    input  logic [DataWidth-1:0]               wdata1,
    input  logic [NumReadPorts*IndexWidth-1:0] raddr,
    output logic [NumReadPorts*DataWidth-1:0]  rdata,
    input  logic                               irqEnter,
    input  logic                               irqReturn,
    output logic [DataWidth-1:0]               programCounter,
    output logic                               inIrq
);

    bank_state_e state;
    bank_state_e next_state;
    logic        irq_pc_load;
    logic        normal_active;
    logic        irq_active;

    write_port_t [1:0] raw_wport;
    write_port_t [1:0] normal_wport;
    write_port_t [1:0] irq_wport;

    logic [NumReadPorts*DataWidth-1:0] normal_rdata;
    logic [NumReadPorts*DataWidth-1:0] irq_rdata;
    logic [DataWidth-1:0]              normal_pc;
    logic [DataWidth-1:0]              irq_pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= BANK_NORMAL;
        end else begin
            state <= next_state;
        end
    end

    // No nesting: enter only counts in NORMAL, return only in IRQ.
    always_comb begin
        next_state  = state;
        irq_pc_load = 1'b0;
        case (state)
            BANK_NORMAL: begin
                if (irqEnter) begin
                    next_state  = BANK_IRQ;
                    irq_pc_load = 1'b1;
                end
            end
            BANK_IRQ: begin
                if (irqReturn) begin
                    next_state = BANK_NORMAL;
                end
            end
            default: next_state = BANK_NORMAL;
        endcase
    end

    assign normal_active = (state == BANK_NORMAL);
    assign irq_active    = (state == BANK_IRQ);

    // Gating uses the current state, so transition-cycle writes land in the outgoing bank.
    always_comb begin
        raw_wport[0] = '{we: we0, addr: MAX_INDEX_WIDTH'(waddr0), data: MAX_DATA_WIDTH'(wdata0)};
        raw_wport[1] = '{we: we1, addr: MAX_INDEX_WIDTH'(waddr1), data: MAX_DATA_WIDTH'(wdata1)};
        normal_wport = raw_wport;
        irq_wport    = raw_wport;
        normal_wport[0].we = we0 && normal_active;
        normal_wport[1].we = we1 && normal_active;
        irq_wport[0].we    = we0 && irq_active;
        irq_wport[1].we    = we1 && irq_active;
    end

    regfile_bank #(
        .DataWidth    (DataWidth),
        .NumRegs      (NumRegs),
        .NumReadPorts (NumReadPorts),
        .PcStep       (PcStep),
        .PcInit       ('0),
        .IndexWidth   (IndexWidth)
    ) u_normal_bank (
        .clk     (clk),
        .rst     (rst),
        .count   (countEnable && normal_active),
        .pc_load (1'b0),
        .wport   (normal_wport),
        .raddr   (raddr),
        .rdata   (normal_rdata),
        .pc      (normal_pc)
    );

    regfile_bank #(
        .DataWidth    (DataWidth),
        .NumRegs      (NumRegs),
        .NumReadPorts (NumReadPorts),
        .PcStep       (PcStep),
        .PcInit       (IrqVector),
        .IndexWidth   (IndexWidth)
    ) u_irq_bank (
        .clk     (clk),
        .rst     (rst),
        .count   (countEnable && irq_active),
        .pc_load (irq_pc_load),
        .wport   (irq_wport),
        .raddr   (raddr),
        .rdata   (irq_rdata),
        .pc      (irq_pc)
    );

    assign rdata          = irq_active ? irq_rdata : normal_rdata;
    assign programCounter = irq_active ? irq_pc : normal_pc;
    assign inIrq          = irq_active;

endmodule

// File: tb/tb_banked_register_file.sv
// Directed bench for banked_register_file: a bank-level model is compared against
// the DUT every cycle, alongside hand-computed literal checks.
module tb_banked_register_file;

    localparam int          DW   = 16;
    localparam int          NR   = 8;
    localparam int          NRP  = 2;
    localparam int          IW   = 3;
    localparam logic [15:0] IRQV = 16'h0010;
    localparam logic [15:0] STEP = 16'd1;

    logic              clk;
    logic              rst;
    logic              countEnable;
    logic              we0;
    logic [IW-1:0]     waddr0;
    logic [DW-1:0]     wdata0;
    logic              we1;
    logic [IW-1:0]     waddr1;
    logic [DW-1:0]     wdata1;
    logic [NRP*IW-1:0] raddr;
    logic [NRP*DW-1:0] rdata;
    logic              irqEnter;
    logic              irqReturn;
    logic [DW-1:0]     programCounter;
    logic              inIrq;

    int checks = 0;
    int passes = 0;

    logic [15:0] mreg [2][NR];
    int          mmode;

    banked_register_file #(
        .DataWidth    (DW),
        .NumRegs      (NR),
        .NumReadPorts (NRP),
        .PcStep       (1),
        .IrqVector    (IRQV)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .countEnable    (countEnable),
        .we0            (we0),
        .waddr0         (waddr0),
        .wdata0         (wdata0),
        .we1            (we1),
        .waddr1         (waddr1),
        .wdata1         (wdata1),
        .raddr          (raddr),
        .rdata          (rdata),
        .irqEnter       (irqEnter),
        .irqReturn      (irqReturn),
        .programCounter (programCounter),
        .inIrq          (inIrq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] modelRead(input int a);
        return (a == 0) ? 16'h0000 : mreg[mmode][a];
    endfunction

    // Bank-level model: the active bank takes increment, then port 0, then port 1 writes.
    always @(posedge clk or negedge rst) begin
        int cur;
        if (!rst) begin
            for (int b = 0; b < 2; b++)
                for (int r = 0; r < NR; r++)
                    mreg[b][r] = 16'h0000;
            mreg[1][NR-1] = IRQV;
            mmode = 0;
        end else begin
            cur = mmode;
            if (countEnable) mreg[cur][NR-1] = mreg[cur][NR-1] + STEP;
            if (we0 && waddr0 != 0) mreg[cur][waddr0] = wdata0;
            if (we1 && waddr1 != 0) mreg[cur][waddr1] = wdata1;
            if (mmode == 0 && irqEnter) begin
                mreg[1][NR-1] = IRQV;
                mmode = 1;
            end else if (mmode == 1 && irqReturn) begin
                mmode = 0;
            end
        end
    end

    always @(negedge clk) begin
        logic [15:0] exp;
        for (int k = 0; k < NRP; k++) begin
            exp = modelRead(int'(raddr[k*IW +: IW]));
            checks++;
            if (rdata[k*DW +: DW] == exp) passes++;
            else $display("[TB] FAIL model_rdata%0d: got %h, expected %h", k, rdata[k*DW +: DW], exp);
        end
        checks++;
        if (programCounter == mreg[mmode][NR-1]) passes++;
        else $display("[TB] FAIL model_pc: got %h, expected %h", programCounter, mreg[mmode][NR-1]);
        checks++;
        if (inIrq == (mmode == 1)) passes++;
        else $display("[TB] FAIL model_inIrq: got %0d, expected %0d", inIrq, (mmode == 1));
    end

    task automatic applyStimulus(input int ce, input int w0, input int a0, input int d0,
                                 input int w1, input int a1, input int d1,
                                 input int ent, input int ret);
        @(negedge clk);
        #1;
        countEnable = (ce != 0);
        we0         = (w0 != 0);
        waddr0      = IW'(a0);
        wdata0      = DW'(d0);
        we1         = (w1 != 0);
        waddr1      = IW'(a1);
        wdata1      = DW'(d1);
        irqEnter    = (ent != 0);
        irqReturn   = (ret != 0);
        @(posedge clk);
        #1;
        countEnable = 1'b0;
        we0         = 1'b0;
        we1         = 1'b0;
        irqEnter    = 1'b0;
        irqReturn   = 1'b0;
    endtask

    task automatic setRead(input int a0, input int a1);
        raddr = {IW'(a1), IW'(a0)};
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act == exp) passes++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    initial begin
        rst = 1'b0;
        countEnable = 1'b0;
        we0 = 1'b0; waddr0 = '0; wdata0 = '0;
        we1 = 1'b0; waddr1 = '0; wdata1 = '0;
        irqEnter = 1'b0; irqReturn = 1'b0;
        raddr = '0;

        repeat (3) @(posedge clk);
        #1;
        setRead(3, 7);
        checkOutput("reset_pc", programCounter, 16'h0000);
        checkOutput("reset_inIrq", 16'(inIrq), 16'h0000);
        checkOutput("reset_rd0", rdata[15:0], 16'h0000);
        checkOutput("reset_rd1", rdata[31:16], 16'h0000);
        @(negedge clk);
        #1 rst = 1'b1;

        repeat (3) applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("pc_count3", programCounter, 16'h0003);

        applyStimulus(0, 1, 3, 16'hAAAA, 1, 3, 16'h5555, 0, 0);
        setRead(3, 0);
        checkOutput("port1_wins", rdata[15:0], 16'h5555);
        applyStimulus(0, 1, 0, 16'h1234, 0, 0, 0, 0, 0);
        setRead(0, 3);
        checkOutput("zero_reg", rdata[15:0], 16'h0000);
        checkOutput("r3_kept", rdata[31:16], 16'h5555);
        applyStimulus(0, 1, 4, 16'h4444, 1, 5, 16'h0505, 0, 0);
        setRead(4, 5);
        checkOutput("dual_write_r4", rdata[15:0], 16'h4444);
        checkOutput("dual_write_r5", rdata[31:16], 16'h0505);

        applyStimulus(0, 0, 0, 0, 1, 7, 16'hFFFF, 0, 0);
        checkOutput("pc_written", programCounter, 16'hFFFF);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("pc_wrap", programCounter, 16'h0000);
        applyStimulus(0, 0, 0, 0, 1, 7, 16'hFFFF, 0, 0);
        applyStimulus(1, 1, 7, 16'h0040, 0, 0, 0, 0, 0);
        checkOutput("pc_write_beats_inc", programCounter, 16'h0040);

        applyStimulus(0, 1, 2, 16'h00AB, 1, 7, 16'h0020, 0, 0);
        setRead(2, 7);
        checkOutput("normal_r2", rdata[15:0], 16'h00AB);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 0);
        checkOutput("enter_inIrq", 16'(inIrq), 16'h0001);
        checkOutput("enter_pc", programCounter, 16'h0010);
        checkOutput("irq_r2_empty", rdata[15:0], 16'h0000);
        checkOutput("irq_read_pc", rdata[31:16], 16'h0010);
        applyStimulus(0, 1, 2, 16'h0F0F, 0, 0, 0, 0, 0);
        checkOutput("irq_r2", rdata[15:0], 16'h0F0F);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
        checkOutput("ret_inIrq", 16'(inIrq), 16'h0000);
        checkOutput("ret_r2", rdata[15:0], 16'h00AB);
        checkOutput("ret_pc", programCounter, 16'h0021);

        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
        checkOutput("reenter_pc", programCounter, 16'h0010);
        checkOutput("reenter_r2_kept", rdata[15:0], 16'h0F0F);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("irq_count", programCounter, 16'h0011);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
        checkOutput("nested_enter_state", 16'(inIrq), 16'h0001);
        checkOutput("nested_enter_pc", programCounter, 16'h0011);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1);
        checkOutput("both_in_irq", 16'(inIrq), 16'h0000);
        checkOutput("both_in_irq_pc", programCounter, 16'h0021);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
        checkOutput("stray_return", 16'(inIrq), 16'h0000);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1);
        checkOutput("both_in_normal", 16'(inIrq), 16'h0001);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);

        applyStimulus(0, 1, 1, 16'h1111, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
        applyStimulus(1, 1, 3, 16'h3333, 0, 0, 0, 0, 0);
        setRead(1, 3);
        checkOutput("irq_r3", rdata[31:16], 16'h3333);
        checkOutput("irq_pc_pre_reset", programCounter, 16'h0011);
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        checkOutput("midreset_inIrq", 16'(inIrq), 16'h0000);
        checkOutput("midreset_pc", programCounter, 16'h0000);
        checkOutput("midreset_rd0", rdata[15:0], 16'h0000);
        checkOutput("midreset_rd1", rdata[31:16], 16'h0000);
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
        checkOutput("post_reset_enter_pc", programCounter, 16'h0010);
        checkOutput("post_reset_irq_r3", rdata[31:16], 16'h0000);

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/banked_register_file.md
Name: banked_register_file

Overview:
- Next-generation CPU register file. Width, register count and read-port count are parametrised, and the block has two write ports.
- A programmable-step program counter sits in the top register, and register 0 reads as a hard-wired zero.
- Adds a two-bank shadow scheme: interrupt entry switches to a private register bank in one cycle, and return restores the interrupted context untouched.
- Sits between decode/writeback and the fetch unit of the cpu16 core.

Parameters:
- DataWidth, 16, register width in bits.
- NumRegs, 8, registers per bank. Index 0 is the zero register; index NumRegs-1 is the PC. Must be at least 4.
- NumReadPorts, 2, number of combinational read ports.
- PcStep, 1, PC increment applied on countEnable. Added modulo 2^DataWidth.
- IrqVector, 16'h0010, value loaded into the IRQ-bank PC on interrupt entry. Width DataWidth.
- IndexWidth, $clog2(NumRegs), derived register index width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- countEnable  in  1  advance the active-bank PC by PcStep.
- we0  in  1  write enable, port 0.
- waddr0  in  IndexWidth  write address, port 0.
- wdata0  in  DataWidth  write data, port 0.
- we1  in  1  write enable, port 1 (higher priority).
- waddr1  in  IndexWidth  write address, port 1.
- wdata1  in  DataWidth  write data, port 1.
- raddr  in  NumReadPorts*IndexWidth  packed read addresses; port k uses slice k.
- rdata  out  NumReadPorts*DataWidth  packed read data; port k uses slice k.
- irqEnter  in  1  single-cycle pulse: switch to the IRQ bank.
- irqReturn  in  1  single-cycle pulse: switch back to the normal bank.
- programCounter  out  DataWidth  active-bank PC.
- inIrq  out  1  1 while the IRQ bank is active.

Behaviour:
- Storage is two banks, NORMAL and IRQ, each holding NumRegs-1 physical registers (indices 1..NumRegs-1). Index 0 has no storage.
- Reset (rst=0, asynchronous):
  - All registers in both banks clear to 0, except the IRQ-bank PC, which resets to IrqVector.
  - Bank FSM goes to NORMAL, so inIrq=0 and programCounter=0.
- Reads are combinational from the active bank.
  - Index 0 always returns 0.
  - No write-through: a write becomes visible on the cycle after the clock edge.
- Writes:
  - Each enabled port writes the active bank at the clock edge.
  - Writes to index 0 are discarded.
  - Both ports enabled to the same address: port 1 wins.
- PC:
  - countEnable adds PcStep to the active PC, truncated to DataWidth, so it wraps.
  - Any enabled write to index NumRegs-1 overrides the increment in that cycle.
- Bank FSM has two states, NORMAL and IRQ:
  - NORMAL + irqEnter -> IRQ. In the same edge, the IRQ-bank PC loads IrqVector. Other IRQ-bank registers keep their prior contents.
  - IRQ + irqReturn -> NORMAL.
  - irqEnter while in IRQ is ignored (no nesting).
  - irqReturn while in NORMAL is ignored.
  - Both pulses together: in NORMAL, enter takes effect; in IRQ, return takes effect.
- Transition cycle:
  - Writes and PC increment presented in the same cycle as a transition apply to the outgoing (old) bank.
  - In NORMAL->IRQ, IrqVector has priority on the IRQ-bank PC.
  - Reads switch bank the cycle after the edge.
- The inactive bank is frozen: no writes and no increments reach it.
- Reset asserted mid-operation restores full reset state immediately, regardless of FSM state.

Decomposition:
- Package cpu16_regfile_pkg holds:
  - bank_state_e enum {BANK_NORMAL, BANK_IRQ};
  - constants ZERO_IDX=0 and a function pc_idx(NumRegs);
  - a write-port struct {we, addr, data} to build the two-port write array.
- One natural sub-module, regfile_bank: a single bank with two write ports, count/load PC and a combinational read mux. It is instantiated twice.
- The top level holds the FSM, the enable gating and the read-output mux.

Test Plan:
- Reset then release: all rdata=0, programCounter=0, inIrq=0. Assert countEnable for 3 cycles with PcStep=1 -> programCounter=3.
- we0 addr3=16'hAAAA and we1 addr3=16'h5555 in the same cycle -> next cycle, reading addr 3 returns 16'h5555. A write of 16'h1234 to addr 0 -> reading addr 0 returns 0.
- PC=16'hFFFF with countEnable and PcStep=1 -> PC wraps to 16'h0000. The same cycle with we0 to addr 7 with 16'h0040 -> PC=16'h0040, no increment.
- Start in NORMAL with r2=16'h00AB and PC=16'h0020. Pulse irqEnter with countEnable=1 -> next cycle inIrq=1, programCounter=16'h0010. Write r2=16'h0F0F, then pulse irqReturn -> inIrq=0, r2=16'h00AB, PC=16'h0021.
- In IRQ, pulse irqEnter alone -> state and PC unchanged. Pulse irqEnter and irqReturn together -> returns to NORMAL. In NORMAL, pulse irqReturn -> ignored.
- Drop rst mid-IRQ with nonzero registers -> immediately inIrq=0, all reads 0. After release, the IRQ-bank PC equals IrqVector at the next entry.
